// File: rtl/lnic_net_pkg.sv
// lnic_net_pkg
//  Shared constants and types for the simulated-network TX path.
//  NET_DATA_W / NET_KEEP_W : width of one stream beat and its byte enables
//  arb_state_t             : TX arbiter state (IDLE = choosing a port, XFER = packet in flight)
package lnic_net_pkg;

    localparam int NET_DATA_W = 64;
    localparam int NET_KEEP_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/lnic_tx_arbiter_if.sv
// lnic_tx_arbiter_if
//  Bundles the N_PORTS source streams and the merged network stream of the TX arbiter.
//  in_valid/in_ready/in_last : per-port handshake and end-of-packet, one bit per port
//  in_data/in_keep           : per-port beat payload, port i at [W*i +: W]
//  net_out_*                 : merged stream towards the network endpoint
//  master : the side that drives the sources and the downstream ready
//  slave  : the arbiter itself
interface lnic_tx_arbiter_if #(
    parameter int N_PORTS = 4
);
    import lnic_net_pkg::*;

    logic [N_PORTS-1:0]            in_valid;
    logic [N_PORTS-1:0]            in_ready;
    logic [N_PORTS*NET_DATA_W-1:0] in_data;
    logic [N_PORTS*NET_KEEP_W-1:0] in_keep;
    logic [N_PORTS-1:0]            in_last;

    logic                  net_out_valid;
    logic                  net_out_ready;
    logic [NET_DATA_W-1:0] net_out_data;
    logic [NET_KEEP_W-1:0] net_out_keep;
    logic                  net_out_last;

    modport master (
        output in_valid, in_data, in_keep, in_last, net_out_ready,
        input  in_ready, net_out_valid, net_out_data, net_out_keep, net_out_last
    );

    modport slave (
        input  in_valid, in_data, in_keep, in_last, net_out_ready,
        output in_ready, net_out_valid, net_out_data, net_out_keep, net_out_last
    );

endinterface

// File: rtl/lnic_token_bucket.sv
// lnic_token_bucket
//  Token-bucket rate limiter for the TX arbiter.
//  clock, reset : clock and synchronous active-high reset
//  inc_i        : tokens added per refill
//  period_i     : a refill happens every period_i+1 cycles
//  size_i       : bucket capacity; 0 bypasses the limiter (tokens held at 0)
//  consume_i    : one beat was transferred this cycle
//  allow_o      : a beat may be offered this cycle
module lnic_token_bucket #(
    parameter int TOKEN_W = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] inc_i,
    input  logic [7:0] period_i,
    input  logic [7:0] size_i,
    input  logic       consume_i,
    output logic       allow_o
);

    localparam logic [TOKEN_W:0] ONE = {{TOKEN_W{1'b0}}, 1'b1};

    logic [7:0]         periodCnt_q, periodCnt_d;
    logic [TOKEN_W-1:0] tokens_q, tokens_d;
    logic               refill;
    logic [TOKEN_W:0]   sum;
    logic [TOKEN_W:0]   sizeExt;
    logic [TOKEN_W:0]   filled;

    always_ff @(posedge clock) begin
        if (reset) begin
            periodCnt_q <= '0;
            tokens_q    <= '0;
        end else begin
            periodCnt_q <= periodCnt_d;
            tokens_q    <= tokens_d;
        end
    end

    // The >= compare lets a live shrink of period_i wrap the counter at once.
    // The refill sum is one bit wider than the counter so it saturates instead of wrapping.
    // A consume can only happen while tokens are non-zero, so filled-1 never underflows.
    always_comb begin
        refill      = (periodCnt_q >= period_i);
        periodCnt_d = refill ? 8'd0 : periodCnt_q + 8'd1;
        sum         = {1'b0, tokens_q} + (TOKEN_W+1)'(inc_i);
        sizeExt     = (TOKEN_W+1)'(size_i);
        filled      = {1'b0, tokens_q};
        if (refill) begin
            filled = (sum > sizeExt) ? sizeExt : sum;
        end
        if (size_i == 8'd0) begin
            tokens_d = '0;
        end else if (consume_i) begin
            tokens_d = TOKEN_W'(filled - ONE);
        end else begin
            tokens_d = TOKEN_W'(filled);
        end
    end

    assign allow_o = (size_i == 8'd0) || (tokens_q != '0);

endmodule

// File: rtl/lnic_tx_arbiter.sv
// lnic_tx_arbiter
//  Merges N_PORTS packet sources onto one 64-bit network TX stream with packet-granular
//  round-robin arbitration, gated by a token-bucket rate limiter.
//  clock, reset  : clock and synchronous active-high reset
//  bus           : source streams and merged output stream (lnic_tx_arbiter_if.slave)
//  rlimit_inc    : tokens added per refill
//  rlimit_period : refill every rlimit_period+1 cycles
//  rlimit_size   : bucket capacity; 0 bypasses the limiter
//  grant_idx     : currently / last granted port
//  busy          : high while a packet is in flight
module lnic_tx_arbiter
    import lnic_net_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int TOKEN_W = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    lnic_tx_arbiter_if.slave           bus,
    input  logic [7:0]                 rlimit_inc,
    input  logic [7:0]                 rlimit_period,
    input  logic [7:0]                 rlimit_size,
    output logic [$clog2(N_PORTS)-1:0] grant_idx,
    output logic                       busy
);

    localparam int IDX_W = $clog2(N_PORTS);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic             allow;
    logic             xfer;
    logic             found;
    int               searchIdx;

    lnic_token_bucket #(
        .TOKEN_W (TOKEN_W)
    ) u_bucket (
        .clock     (clock),
        .reset     (reset),
        .inc_i     (rlimit_inc),
        .period_i  (rlimit_period),
        .size_i    (rlimit_size),
        .consume_i (xfer),
        .allow_o   (allow)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    // In IDLE the first requesting port at or after rr_q (with wrap) wins; the grant is
    // only registered here, so every packet pays one arbitration cycle. The pointer moves
    // past the winner only when its last beat leaves, which keeps grants packet-granular.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        found     = 1'b0;
        searchIdx = 0;
        case (state_q)
            IDLE: begin
                for (int i = 0; i < N_PORTS; i++) begin
                    searchIdx = (int'(rr_q) + i) % N_PORTS;
                    if (!found && bus.in_valid[searchIdx]) begin
                        found   = 1'b1;
                        grant_d = IDX_W'(searchIdx);
                    end
                end
                if (found) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (xfer && bus.in_last[grant_q]) begin
                    state_d = IDLE;
                    rr_d    = (int'(grant_q) == N_PORTS - 1) ? '0 : IDX_W'(int'(grant_q) + 1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Valid is built from the granted source and the limiter only, never from net_out_ready.
    always_comb begin
        bus.net_out_data  = bus.in_data[int'(grant_q)*NET_DATA_W +: NET_DATA_W];
        bus.net_out_keep  = bus.in_keep[int'(grant_q)*NET_KEEP_W +: NET_KEEP_W];
        bus.net_out_last  = bus.in_last[grant_q];
        bus.net_out_valid = (state_q == XFER) && bus.in_valid[grant_q] && allow;
        bus.in_ready      = '0;
        if (state_q == XFER) begin
            bus.in_ready[grant_q] = bus.net_out_ready && allow;
        end
        xfer      = bus.net_out_valid && bus.net_out_ready;
        busy      = (state_q == XFER);
        grant_idx = grant_q;
    end

endmodule
